spram_arb_ctrl: RTL and testbench

- Sequencer and 2-requester arbiter in front of one single-port cache RAM (generic_spram instance).
- After reset or on flush request, sweeps every entry to zero. It then time-multiplexes read/write requests from two clients onto the single RAM port with round-robin priority.
- Tracks read latency and returns read data, tagged with the requester id.
- Sits between cache pipeline clients (e.g. lookup, refill) and the tag/data RAM.

---
 rtl/spram_arb_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spram_arb_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arb_ctrl.sv
// Sequencer and two-requester round-robin arbiter in front of a single-port RAM.
// Zero-sweeps the RAM after reset or flush, then multiplexes client requests onto
// the RAM port and returns read data tagged with the requester id.
module spram_arb_ctrl #(
    parameter int unsigned w           = 64,
    parameter int unsigned p           = 8,
    parameter int unsigned d           = 64,
    parameter int unsigned log2d       = 6,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    output logic               init_done_o,

    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic               req0_we_i,
    input  logic [w/p-1:0]     req0_biten_i,
    input  logic [log2d-1:0]   req0_addr_i,
    input  logic [w-1:0]       req0_wdata_i,

    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic               req1_we_i,
    input  logic [w/p-1:0]     req1_biten_i,
    input  logic [log2d-1:0]   req1_addr_i,
    input  logic [w-1:0]       req1_wdata_i,

    output logic               rsp_valid_o,
    output logic               rsp_id_o,
    output logic [w-1:0]       rsp_rdata_o,

    output logic               ram_ce_o,
    output logic               ram_we_o,
    output logic [w/p-1:0]     ram_biten_o,
    output logic [log2d-1:0]   ram_addr_o,
    output logic [w-1:0]       ram_din_o,
    input  logic [w-1:0]       ram_dout_i
);

    localparam int unsigned BW = w / p;

    typedef enum logic [1:0] {StInit, StRun, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [log2d-1:0]       sweep_q, sweep_d;
    logic                   rr_q, rr_d;
    logic [RAM_LATENCY-1:0] pv_q, pv_d;
    logic [RAM_LATENCY-1:0] pid_q, pid_d;

    logic                   gnt0, gnt1, gnt_any, gnt_id;
    logic                   sel_we;
    logic [BW-1:0]          sel_biten;
    logic [log2d-1:0]       sel_addr;
    logic [w-1:0]           sel_wdata;

    // Grant decision: only in RUN, flush blocks all grants, rr pointer breaks ties.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StRun && !flush_i) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt0 = ~rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign gnt_id    = gnt1;
    assign sel_we    = gnt1 ? req1_we_i    : req0_we_i;
    assign sel_biten = gnt1 ? req1_biten_i : req0_biten_i;
    assign sel_addr  = gnt1 ? req1_addr_i  : req0_addr_i;
    assign sel_wdata = gnt1 ? req1_wdata_i : req0_wdata_i;

    // FSM next state, sweep counter and round-robin pointer.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        rr_d    = rr_q;
        unique case (state_q)
            StInit: begin
                if (sweep_q == log2d'(d - 1)) begin
                    sweep_d = '0;
                    state_d = StRun;
                end else begin
                    sweep_d = sweep_q + log2d'(1);
                end
            end
            StRun: begin
                if (flush_i) begin
                    state_d = StDrain;
                end
                if (gnt_any) begin
                    rr_d = ~gnt_id;
                end
            end
            StDrain: begin
                // Let in-flight reads return before the sweep overwrites the RAM.
                if (pv_q == '0) begin
                    state_d = StInit;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = StInit;
                sweep_d = '0;
            end
        endcase
    end

    // Read response pipe: one stage per cycle of RAM latency.
    always_comb begin
        pv_d  = (pv_q << 1) | RAM_LATENCY'(gnt_any & ~sel_we);
        pid_d = (pid_q << 1) | RAM_LATENCY'(gnt_id);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StInit;
            sweep_q <= '0;
            rr_q    <= 1'b0;
            pv_q    <= '0;
            pid_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            rr_q    <= rr_d;
            pv_q    <= pv_d;
            pid_q   <= pid_d;
        end
    end

    // RAM port drive; everything is forced idle while reset is held.
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_biten_o = '0;
        ram_addr_o  = '0;
        ram_din_o   = '0;
        if (rst_n) begin
            if (state_q == StInit) begin
                ram_ce_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_biten_o = '1;
                ram_addr_o  = sweep_q;
            end else if (gnt_any) begin
                ram_ce_o    = 1'b1;
                ram_we_o    = sel_we;
                ram_biten_o = sel_we ? sel_biten : '0;
                ram_addr_o  = sel_addr;
                ram_din_o   = sel_wdata;
            end
        end
    end

    assign req0_ready_o = rst_n & gnt0;
    assign req1_ready_o = rst_n & gnt1;
    assign init_done_o  = rst_n & (state_q == StRun);
    assign rsp_valid_o  = rst_n & pv_q[RAM_LATENCY-1];
    assign rsp_id_o     = pid_q[RAM_LATENCY-1];
    assign rsp_rdata_o  = ram_dout_i;

endmodule

// File: tb/tb_spram_arb_ctrl.sv
// Randomized scoreboard bench for spram_arb_ctrl with a behavioural RAM and
// reference model; a second instance with two-cycle latency gets a directed run.
module tb_spram_arb_ctrl;

    localparam int unsigned W   = 64;
    localparam int unsigned P   = 8;
    localparam int unsigned D   = 64;
    localparam int unsigned AW  = 6;
    localparam int unsigned LAT = 1;
    localparam int unsigned BW  = W / P;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic          rst_n, flush;
    logic          v0, v1, we0, we1;
    logic [BW-1:0] be0, be1;
    logic [AW-1:0] a0, a1;
    logic [W-1:0]  wd0, wd1;
    logic          rdy0, rdy1, init_done, rsp_valid, rsp_id;
    logic [W-1:0]  rsp_rdata;
    logic          ram_ce, ram_we;
    logic [BW-1:0] ram_biten;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_din, ram_dout;

    spram_arb_ctrl #(.w(W), .p(P), .d(D), .log2d(AW), .RAM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .init_done_o(init_done),
        .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_we_i(we0), .req0_biten_i(be0),
        .req0_addr_i(a0), .req0_wdata_i(wd0),
        .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_we_i(we1), .req1_biten_i(be1),
        .req1_addr_i(a1), .req1_wdata_i(wd1),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_rdata_o(rsp_rdata),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_biten_o(ram_biten),
        .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    // Second instance, two-cycle RAM latency
    logic          rst2_n, v0_2, zero_b;
    logic [BW-1:0] zero_be;
    logic [AW-1:0] a0_2, zero_a;
    logic [W-1:0]  zero_w, dout2;
    logic          rdy0_2, rdy1_2, init2, rspv2, rspid2, ce2, we2o;
    logic [W-1:0]  rspd2, din2o;
    logic [BW-1:0] be2o;
    logic [AW-1:0] addr2o;
    logic          done2;

    spram_arb_ctrl #(.w(W), .p(P), .d(D), .log2d(AW), .RAM_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .flush_i(zero_b), .init_done_o(init2),
        .req0_valid_i(v0_2), .req0_ready_o(rdy0_2), .req0_we_i(zero_b),
        .req0_biten_i(zero_be), .req0_addr_i(a0_2), .req0_wdata_i(zero_w),
        .req1_valid_i(zero_b), .req1_ready_o(rdy1_2), .req1_we_i(zero_b),
        .req1_biten_i(zero_be), .req1_addr_i(zero_a), .req1_wdata_i(zero_w),
        .rsp_valid_o(rspv2), .rsp_id_o(rspid2), .rsp_rdata_o(rspd2),
        .ram_ce_o(ce2), .ram_we_o(we2o), .ram_biten_o(be2o),
        .ram_addr_o(addr2o), .ram_din_o(din2o), .ram_dout_i(dout2)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] byte_mask(input logic [BW-1:0] be);
        logic [W-1:0] m;
        m = '0;
        for (int b = 0; b < BW; b++) if (be[b]) m[b*P +: P] = '1;
        return m;
    endfunction

    // Behavioural single-port RAM, one cycle read latency, starts full of garbage.
    logic [W-1:0] ram_mem [D];
    initial for (int i = 0; i < D; i++) ram_mem[i] = {$urandom, $urandom};
    always @(posedge clk) begin : ram_model
        logic [W-1:0] nw;
        if (ram_ce) begin
            if (ram_we) begin
                nw = ram_mem[ram_addr];
                for (int b = 0; b < BW; b++)
                    if (ram_biten[b]) nw[b*P +: P] = ram_din[b*P +: P];
                ram_mem[ram_addr] <= nw;
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    // Reference model and scoreboard
    typedef struct {
        int           id;
        logic [W-1:0] data;
        longint       due;
    } rsp_t;
    rsp_t sb_q[$];

    typedef enum int {MInit, MRun, MDrain} mode_e;
    mode_e        m_mode   = MInit;
    int           m_idx    = 0;
    int           m_rr     = 0;
    longint       m_lastdue = -1;
    logic [W-1:0] ref_mem [D];

    // Predict this cycle's outputs from the inputs, then advance the model.
    always @(negedge clk) begin : model
        int           g;
        logic         gw;
        logic [BW-1:0] gb;
        logic [AW-1:0] ga;
        logic [W-1:0]  gd;
        rsp_t          e;
        if (!rst_n) begin
            chk("rst_ready0", rdy0, 0);
            chk("rst_ready1", rdy1, 0);
            chk("rst_ce", ram_ce, 0);
            chk("rst_init_done", init_done, 0);
            m_mode = MInit; m_idx = 0; m_rr = 0; m_lastdue = -1;
            sb_q.delete();
        end else begin
            case (m_mode)
                MInit: begin
                    chk("init_ce", ram_ce, 1);
                    chk("init_we", ram_we, 1);
                    chk("init_biten", ram_biten, {BW{1'b1}});
                    chk("init_addr", ram_addr, m_idx);
                    chk("init_din", ram_din, 0);
                    chk("init_ready0", rdy0, 0);
                    chk("init_ready1", rdy1, 0);
                    chk("init_done_low", init_done, 0);
                    m_idx++;
                    if (m_idx == D) begin
                        m_mode = MRun; m_idx = 0;
                        for (int i = 0; i < D; i++) ref_mem[i] = '0;
                    end
                end
                MRun: begin
                    chk("run_init_done", init_done, 1);
                    if (flush) begin
                        chk("flush_ready0", rdy0, 0);
                        chk("flush_ready1", rdy1, 0);
                        chk("flush_ce", ram_ce, 0);
                        m_mode = MDrain;
                    end else begin
                        if (v0 && v1) g = m_rr;
                        else if (v0) g = 0;
                        else if (v1) g = 1;
                        else g = -1;
                        chk("ready0", rdy0, g == 0);
                        chk("ready1", rdy1, g == 1);
                        chk("run_ce", ram_ce, g >= 0);
                        if (g < 0) begin
                            chk("idle_we", ram_we, 0);
                        end else begin
                            gw = (g == 1) ? we1 : we0;
                            gb = (g == 1) ? be1 : be0;
                            ga = (g == 1) ? a1 : a0;
                            gd = (g == 1) ? wd1 : wd0;
                            chk("gnt_we", ram_we, gw);
                            chk("gnt_addr", ram_addr, ga);
                            chk("gnt_din", ram_din, gd);
                            chk("gnt_biten", ram_biten, gw ? gb : '0);
                            m_rr = 1 - g;
                            if (gw) begin
                                ref_mem[ga] = (ref_mem[ga] & ~byte_mask(gb)) | (gd & byte_mask(gb));
                            end else begin
                                e.id = g; e.data = ref_mem[ga]; e.due = cyc + LAT;
                                sb_q.push_back(e);
                                m_lastdue = e.due;
                            end
                        end
                    end
                end
                default: begin
                    chk("drain_ready0", rdy0, 0);
                    chk("drain_ready1", rdy1, 0);
                    chk("drain_ce", ram_ce, 0);
                    chk("drain_init_done", init_done, 0);
                    if (m_lastdue < cyc) begin
                        m_mode = MInit; m_idx = 0;
                    end
                end
            endcase
        end
    end

    // Response monitor: pops the scoreboard when a response is due.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!rst_n) begin
            chk("rsp_valid_in_reset", rsp_valid, 0);
        end else if (sb_q.size() == 0 || sb_q[0].due > cyc) begin
            chk("rsp_valid_idle", rsp_valid, 0);
        end else begin
            e = sb_q.pop_front();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_rdata", rsp_rdata, e.data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        v0 = 0; v1 = 0; we0 = 0; we1 = 0; flush = 0;
        be0 = '0; be1 = '0; a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
    endtask

    // Directed run on the two-cycle latency instance.
    initial begin : dut2_seq
        zero_b = 0; zero_be = '0; zero_a = '0; zero_w = '0;
        dout2 = 64'h0123_4567_89ab_cdef;
        done2 = 0; rst2_n = 0; v0_2 = 0; a0_2 = '0;
        repeat (3) @(posedge clk);
        #1 rst2_n = 1;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk("d2_sweep_addr", addr2o, i);
            chk("d2_init_done_low", init2, 0);
            @(posedge clk); #1;
        end
        v0_2 = 1; a0_2 = 6'd17;
        @(negedge clk);
        chk("d2_init_done", init2, 1);
        chk("d2_ready", rdy0_2, 1);
        @(posedge clk); #1 v0_2 = 0;
        @(negedge clk);
        chk("d2_rsp_early", rspv2, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("d2_rsp_valid", rspv2, 1);
        chk("d2_rsp_id", rspid2, 0);
        chk("d2_rsp_rdata", rspd2, dout2);
        @(posedge clk); #1 v0_2 = 1;
        @(negedge clk);
        chk("d2_ready2", rdy0_2, 1);
        @(posedge clk); #1 v0_2 = 0; rst2_n = 0;
        @(negedge clk);
        chk("d2_rsp_in_reset", rspv2, 0);
        chk("d2_reset_init_done", init2, 0);
        @(posedge clk); #1 rst2_n = 1;
        @(negedge clk);
        chk("d2_rsp_dropped", rspv2, 0);
        chk("d2_restart_ce", ce2, 1);
        chk("d2_restart_addr", addr2o, 0);
        chk("d2_restart_init_done", init2, 0);
        done2 = 1;
    end

    // Main stimulus
    initial begin : stim
        rst_n = 0;
        clear_reqs();
        repeat (3) step();
        rst_n = 1;
        repeat (30) step();
        rst_n = 0;              // hit reset while the sweep is at address 30
        step();
        rst_n = 1;
        repeat (D) step();
        // Partial-byte write then read back
        v0 = 1; we0 = 1; a0 = 6'd9; wd0 = '1; be0 = 8'h0F;
        step();
        we0 = 0;
        step();
        v0 = 0;
        step();
        // Contending reads alternate
        v0 = 1; v1 = 1; a0 = 6'd3; a1 = 6'd5;
        repeat (4) step();
        clear_reqs();
        step();
        // Read, then flush while req1 is valid
        v0 = 1; a0 = 6'd9;
        step();
        v0 = 0; v1 = 1; a1 = 6'd5; flush = 1;
        step();
        clear_reqs();
        repeat (D + 6) step();
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            flush = ($urandom_range(0, 59) == 0);
            v0    = ($urandom_range(0, 9) < 6);
            v1    = ($urandom_range(0, 9) < 6);
            we0   = $urandom_range(0, 1);
            we1   = $urandom_range(0, 1);
            be0   = BW'($urandom);
            be1   = BW'($urandom);
            a0    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            a1    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            wd0   = {$urandom, $urandom};
            wd1   = {$urandom, $urandom};
            step();
        end
        rst_n = 1;
        clear_reqs();
        repeat (10) step();
        chk("d2_sequence_done", done2, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
